bip_data_mem_controller: RTL and testbench

BIP_DATA_MEM_CONTROLLER -- requirements
Module: bip_data_mem_controller

---
 rtl/bip_data_mem_controller_if.sv | 54 +++++
 rtl/bip_data_mem_controller.sv | 120 ++++++++++++
 tb/tb_bip_data_mem_controller.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bip_data_mem_controller_if.sv
// Request, write-beat, read-beat and memory-side signals of the burst
// data-memory controller, bundled for the controller and its requester.
//
// Handshake rules: a request transfers on a rising edge where i_req_valid
// and o_req_ready are both 1; a write beat transfers on a rising edge where
// i_wdata_valid and o_wdata_ready are both 1; a valid holder keeps its
// payload stable until the transfer; the read-beat stream has no ready and
// must be consumed in the cycle o_rdata_valid is 1.
interface bip_data_mem_controller_if #(
    parameter int NB_DATA          = 16,
    parameter int LOG2_N_DATA_ADDR = 10
);
    // request channel
    logic                        i_req_valid;
    logic                        o_req_ready;
    logic                        i_req_wr;
    logic [LOG2_N_DATA_ADDR-1:0] i_req_addr;
    logic [LOG2_N_DATA_ADDR-1:0] i_req_len;
    // write-beat stream
    logic                        i_wdata_valid;
    logic                        o_wdata_ready;
    logic [NB_DATA-1:0]          i_wdata;
    // read-beat stream
    logic                        o_rdata_valid;
    logic [NB_DATA-1:0]          o_rdata;
    logic                        o_rdata_last;
    // status
    logic                        o_busy;
    logic                        o_done;
    // data memory side
    logic [LOG2_N_DATA_ADDR-1:0] o_mem_addr;
    logic [NB_DATA-1:0]          o_mem_data;
    logic                        o_mem_wr;
    logic                        o_mem_rd;
    logic [NB_DATA-1:0]          i_mem_data;

    modport slave (
        input  i_req_valid, i_req_wr, i_req_addr, i_req_len,
        input  i_wdata_valid, i_wdata, i_mem_data,
        output o_req_ready, o_wdata_ready,
        output o_rdata_valid, o_rdata, o_rdata_last,
        output o_busy, o_done,
        output o_mem_addr, o_mem_data, o_mem_wr, o_mem_rd
    );

    modport master (
        output i_req_valid, i_req_wr, i_req_addr, i_req_len,
        output i_wdata_valid, i_wdata, i_mem_data,
        input  o_req_ready, o_wdata_ready,
        input  o_rdata_valid, o_rdata, o_rdata_last,
        input  o_busy, o_done,
        input  o_mem_addr, o_mem_data, o_mem_wr, o_mem_rd
    );
endinterface

// File: rtl/bip_data_mem_controller.sv
// Burst controller in front of a single-port data memory. A request carries
// start address and beat count minus one; write beats are streamed straight
// to the memory, read beats are issued back to back and the memory's
// one-cycle-late data is forwarded with a valid/last marker.
module bip_data_mem_controller #(
    parameter int NB_DATA          = 16,
    parameter int N_ADDR           = 1024,
    parameter int LOG2_N_DATA_ADDR = 10
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    bip_data_mem_controller_if.slave bus,
    output logic [1:0]             o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [LOG2_N_DATA_ADDR-1:0] LAST_ADDR = LOG2_N_DATA_ADDR'(N_ADDR - 1);

    state_t                        state_q, state_d;
    logic [LOG2_N_DATA_ADDR-1:0]   addr_q, addr_d;
    logic [LOG2_N_DATA_ADDR-1:0]   cnt_q, cnt_d;
    logic                          rd_pend_q;
    logic                          wr_done_q, wr_done_d;
    logic [LOG2_N_DATA_ADDR-1:0]   addr_inc;
    logic                          mem_wr;
    logic                          mem_rd;
    logic                          req_ready;
    logic                          wdata_ready;

    // Next address with explicit wrap so a non-power-of-two depth also wraps
    assign addr_inc = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;

    // State, burst address/count, read-pending and write-done registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= mem_rd;
            wr_done_q <= wr_done_d;
        end
    end

    // Next-state, address/count update and per-state strobes
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        wr_done_d   = 1'b0;
        mem_wr      = 1'b0;
        mem_rd      = 1'b0;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (bus.i_req_valid) begin
                    addr_d  = bus.i_req_addr;
                    cnt_d   = bus.i_req_len;
                    state_d = bus.i_req_wr ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                wdata_ready = 1'b1;
                if (bus.i_wdata_valid) begin
                    mem_wr = 1'b1;
                    addr_d = addr_inc;
                    if (cnt_q == '0) begin
                        state_d   = ST_IDLE;
                        wr_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_READ: begin
                mem_rd = 1'b1;
                addr_d = addr_inc;
                if (cnt_q == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DRAIN: begin
                // The final read beat is on the return path this cycle
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.o_req_ready   = req_ready;
    assign bus.o_wdata_ready = wdata_ready;
    assign bus.o_mem_wr      = mem_wr;
    assign bus.o_mem_rd      = mem_rd;
    assign bus.o_mem_addr    = addr_q;
    assign bus.o_mem_data    = (state_q == ST_WRITE) ? bus.i_wdata : '0;
    assign bus.o_rdata       = bus.i_mem_data;
    assign bus.o_rdata_valid = rd_pend_q;
    assign bus.o_rdata_last  = (state_q == ST_DRAIN);
    assign bus.o_done        = wr_done_q | (state_q == ST_DRAIN);
    assign bus.o_busy        = (state_q != ST_IDLE);
    assign o_dbg_state       = state_q;

endmodule

// File: tb/tb_bip_data_mem_controller.sv
// Bench for the burst data-memory controller: table of write/read bursts,
// hand-written timing sequences, and a scoreboard fed by the drivers and
// drained by a negedge monitor. A behavioural memory sits on the memory side.
module tb_bip_data_mem_controller;

    localparam int NB_DATA = 16;
    localparam int AW      = 10;

    logic           i_clock;
    logic           i_reset;
    logic [1:0]     dbg_state;

    bip_data_mem_controller_if #(.NB_DATA(NB_DATA), .LOG2_N_DATA_ADDR(AW)) bus ();

    bip_data_mem_controller #(
        .NB_DATA(NB_DATA), .N_ADDR(1024), .LOG2_N_DATA_ADDR(AW)
    ) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .bus        (bus.slave),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset / memory model ----------------
    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    logic [NB_DATA-1:0] mem [1024];
    logic [NB_DATA-1:0] ref_mem [1024];

    always @(posedge i_clock) begin
        if (bus.o_mem_wr) mem[bus.o_mem_addr] <= bus.o_mem_data;
        if (bus.o_mem_rd) bus.i_mem_data <= mem[bus.o_mem_addr];
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic [AW+NB_DATA-1:0] wr_exp_q[$];
    logic [NB_DATA:0]      rd_exp_q[$];
    logic [AW+NB_DATA-1:0] wr_e;
    logic [NB_DATA:0]      rd_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: expected event did not occur as required at %0t", name, $time);
    endtask

    always @(negedge i_clock) begin
        if (bus.o_mem_wr || bus.o_mem_rd)
            check("rw_exclusive", bus.o_mem_wr & bus.o_mem_rd, 1'b0);
        if (bus.o_mem_wr) begin
            if (wr_exp_q.size() == 0) fail_event("wr_unexpected_beat");
            else begin
                wr_e = wr_exp_q.pop_front();
                check("wr_beat", {bus.o_mem_addr, bus.o_mem_data}, wr_e);
            end
        end
        if (bus.o_rdata_valid) begin
            if (rd_exp_q.size() == 0) fail_event("rd_unexpected_beat");
            else begin
                rd_e = rd_exp_q.pop_front();
                check("rd_beat", {bus.o_rdata_last, bus.o_rdata}, rd_e);
            end
        end
        if (bus.o_rdata_last) check("last_needs_valid", bus.o_rdata_valid, 1'b1);
        if (bus.o_done) done_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic send_req(input logic wr, input logic [AW-1:0] addr, input logic [AW-1:0] len);
        int t;
        t = 0;
        bus.i_req_valid = 1'b1;
        bus.i_req_wr    = wr;
        bus.i_req_addr  = addr;
        bus.i_req_len   = len;
        while (!bus.o_req_ready && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) fail_event("req_accept_timeout");
        tick();
        bus.i_req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [AW-1:0] len,
                            input logic gap, input logic [NB_DATA-1:0] base);
        logic [AW-1:0]      a;
        logic [NB_DATA-1:0] d;
        int t;
        send_req(1'b1, addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            if (gap && i == 2) begin
                bus.i_wdata_valid = 1'b0;
                bus.i_wdata       = 16'hDEAD;
                #1;
                check("gap_no_wr", bus.o_mem_wr, 1'b0);
                tick();
            end
            a = addr + AW'(i);
            d = base + NB_DATA'(i);
            wr_exp_q.push_back({a, d});
            ref_mem[a] = d;
            bus.i_wdata_valid = 1'b1;
            bus.i_wdata       = d;
            t = 0;
            while (!bus.o_wdata_ready && t < 50) begin
                tick();
                t++;
            end
            if (t >= 50) fail_event("wdata_ready_timeout");
            tick();
        end
        bus.i_wdata_valid = 1'b0;
        check("wr_done_pulse", bus.o_done, 1'b1);
        check("wr_back_idle", bus.o_busy, 1'b0);
        exp_done++;
        tick();
        check("wr_done_single", bus.o_done, 1'b0);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [AW-1:0] len,
                           input logic [NB_DATA-1:0] exp_first);
        int  t;
        int  beats;
        logic first;
        for (int i = 0; i <= int'(len); i++)
            rd_exp_q.push_back({(i == int'(len)), ref_mem[addr + AW'(i)]});
        send_req(1'b0, addr, len);
        t = 0;
        beats = 0;
        first = 1'b1;
        while (!bus.o_done && t < 2000) begin
            if (bus.o_rdata_valid) begin
                if (first) check("rd_first_data", bus.o_rdata, exp_first);
                first = 1'b0;
                beats++;
            end
            tick();
            t++;
        end
        if (t >= 2000) fail_event("rd_done_timeout");
        else begin
            if (bus.o_rdata_valid) begin
                if (first) check("rd_first_data", bus.o_rdata, exp_first);
                beats++;
            end
            check("rd_last_with_done", bus.o_rdata_last, 1'b1);
            check("rd_beat_count", beats, int'(len) + 1);
            exp_done++;
        end
        tick();
        check("rd_back_idle", {bus.o_busy, bus.o_done, bus.o_rdata_valid}, 3'b000);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic               wr;
        logic [AW-1:0]      addr;
        logic [AW-1:0]      len;
        logic               gap;
        logic [NB_DATA-1:0] data;   // write: first beat value; read: expected first beat
    } burst_t;

    burst_t vec [9];

    initial begin
        logic [AW-1:0]      ra;
        logic [AW-1:0]      rl;
        logic [NB_DATA-1:0] rb;

        vec[0] = '{1'b1, 10'h005, 10'd0, 1'b0, 16'hBEEF};
        vec[1] = '{1'b1, 10'h3FE, 10'd3, 1'b1, 16'h0001};
        vec[2] = '{1'b1, 10'h010, 10'd2, 1'b0, 16'h000A};
        vec[3] = '{1'b1, 10'h020, 10'd7, 1'b0, 16'h0100};
        vec[4] = '{1'b1, 10'h080, 10'd4, 1'b1, 16'h7000};
        vec[5] = '{1'b0, 10'h3FE, 10'd3, 1'b0, 16'h0001};
        vec[6] = '{1'b0, 10'h005, 10'd0, 1'b0, 16'hBEEF};
        vec[7] = '{1'b0, 10'h020, 10'd7, 1'b0, 16'h0100};
        vec[8] = '{1'b0, 10'h080, 10'd4, 1'b0, 16'h7000};

        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

        bus.i_req_valid   = 1'b0;
        bus.i_req_wr      = 1'b0;
        bus.i_req_addr    = '0;
        bus.i_req_len     = '0;
        bus.i_wdata_valid = 1'b0;
        bus.i_wdata       = '0;
        i_reset           = 1'b0;

        // reset state
        #1;
        check("rst_strobes", {bus.o_mem_wr, bus.o_mem_rd, bus.o_rdata_valid, bus.o_rdata_last,
                              bus.o_done, bus.o_busy, bus.o_wdata_ready}, 7'b0);
        check("rst_mem_addr", bus.o_mem_addr, 10'h000);
        check("rst_mem_data", bus.o_mem_data, 16'h0000);
        tick();
        tick();
        i_reset = 1'b1;
        check("rel_req_ready", bus.o_req_ready, 1'b1);
        check("rel_state_idle", dbg_state, 2'd0);
        tick();

        // table-driven bursts
        for (int i = 0; i < 9; i++) begin
            if (vec[i].wr) do_write(vec[i].addr, vec[i].len, vec[i].gap, vec[i].data);
            else           do_read(vec[i].addr, vec[i].len, vec[i].data);
        end

        // read 0x010..0x012 with cycle-exact timing
        rd_exp_q.push_back({1'b0, 16'h000A});
        rd_exp_q.push_back({1'b0, 16'h000B});
        rd_exp_q.push_back({1'b1, 16'h000C});
        send_req(1'b0, 10'h010, 10'd2);
        check("r34_c1", {bus.o_mem_rd, bus.o_mem_addr, bus.o_rdata_valid}, {1'b1, 10'h010, 1'b0});
        tick();
        check("r34_c2", {bus.o_mem_rd, bus.o_mem_addr, bus.o_rdata_valid, bus.o_rdata, bus.o_rdata_last},
              {1'b1, 10'h011, 1'b1, 16'h000A, 1'b0});
        tick();
        check("r34_c3", {bus.o_mem_rd, bus.o_mem_addr, bus.o_rdata_valid, bus.o_rdata, bus.o_rdata_last},
              {1'b1, 10'h012, 1'b1, 16'h000B, 1'b0});
        tick();
        check("r34_c4", {bus.o_mem_rd, bus.o_rdata_valid, bus.o_rdata, bus.o_rdata_last, bus.o_done},
              {1'b0, 1'b1, 16'h000C, 1'b1, 1'b1});
        check("r34_c4_addr", bus.o_mem_addr, 10'h013);
        check("r34_c4_drain", dbg_state, 2'd3);
        exp_done++;
        tick();
        check("r34_c5", {bus.o_rdata_valid, bus.o_done, bus.o_busy}, 3'b000);

        // write len 0 then a read accepted in the done cycle
        send_req(1'b1, 10'h040, 10'd0);
        wr_exp_q.push_back({10'h040, 16'h1234});
        ref_mem[10'h040] = 16'h1234;
        bus.i_wdata_valid = 1'b1;
        bus.i_wdata       = 16'h1234;
        tick();
        bus.i_wdata_valid = 1'b0;
        exp_done++;
        rd_exp_q.push_back({1'b1, 16'h1234});
        bus.i_req_valid = 1'b1;
        bus.i_req_wr    = 1'b0;
        bus.i_req_addr  = 10'h040;
        bus.i_req_len   = 10'd0;
        #1;
        check("r36_done_and_ready", {bus.o_done, bus.o_req_ready}, 2'b11);
        tick();
        bus.i_req_valid = 1'b0;
        check("r36_rd_issue", {bus.o_mem_rd, bus.o_mem_addr}, {1'b1, 10'h040});
        tick();
        check("r36_rd_data", {bus.o_rdata_valid, bus.o_rdata, bus.o_rdata_last, bus.o_done},
              {1'b1, 16'h1234, 1'b1, 1'b1});
        exp_done++;
        tick();
        check("r36_idle", bus.o_busy, 1'b0);

        // reset in the middle of a len-7 read burst
        for (int i = 0; i < 8; i++)
            rd_exp_q.push_back({(i == 7), ref_mem[10'h020 + 10'(i)]});
        send_req(1'b0, 10'h020, 10'd7);
        tick();
        tick();
        i_reset = 1'b0;
        #1;
        check("r35_drop", {bus.o_mem_rd, bus.o_rdata_valid, bus.o_busy, bus.o_done}, 4'b0000);
        check("r35_addr_clear", bus.o_mem_addr, 10'h000);
        check("r35_beats_before_reset", rd_exp_q.size(), 7);
        rd_exp_q.delete();
        tick();
        tick();
        tick();
        i_reset = 1'b1;
        check("r35_ready_after_release", bus.o_req_ready, 1'b1);
        tick();
        check("r35_still_idle", {bus.o_req_ready, bus.o_busy, bus.o_rdata_valid}, 3'b100);

        // random write/read-back bursts
        for (int k = 0; k < 3; k++) begin
            ra = AW'($urandom_range(0, 1023));
            rl = AW'($urandom_range(0, 5));
            rb = NB_DATA'($urandom_range(0, 16'hFFFF));
            do_write(ra, rl, (rl >= 2), rb);
            do_read(ra, rl, rb);
        end

        tick();
        check("done_pulse_count", done_cnt, exp_done);
        check("wr_queue_empty", wr_exp_q.size(), 0);
        check("rd_queue_empty", rd_exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
